hall_emulator: RTL



---
 rtl/hall_emulator.sv | 111 +++++++++++
 1 files changed

// File: rtl/hall_emulator.sv
`default_nettype none
// ============================================================================
// Module   : hall_emulator
// Purpose  : Six-state trapezoidal hall source with programmable step rate,
//            direction, fault-code injection and a signed step-position count.
// Revision : 1.0 - initial release
// ============================================================================
module hall_emulator #(
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          fault_mode,
  output logic                hall_1,
  output logic                hall_2,
  output logic                hall_3,
  output logic [2:0]          sector,
  output logic [POS_W-1:0]    position,
  output logic                step
);

  localparam logic [PERIOD_W-1:0] c_period_one = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]    c_pos_one    = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]          c_fault_lo   = 2'd1;
  localparam logic [1:0]          c_fault_hi   = 2'd2;

  logic [PERIOD_W-1:0] r_cnt;
  logic [2:0]          r_sector;
  logic [2:0]          r_hall;
  logic [POS_W-1:0]    r_position;
  logic                r_step;

  logic                w_run;
  logic                w_take;
  logic [2:0]          w_sector_nxt;
  logic [2:0]          w_hall_nxt;

  // Table code order is hall_1 hall_2 hall_3 (MSB first).
  function automatic logic [2:0] f_hall_code(input logic [2:0] s);
    case (s)
      3'd1:    f_hall_code = 3'b100;
      3'd2:    f_hall_code = 3'b110;
      3'd3:    f_hall_code = 3'b010;
      3'd4:    f_hall_code = 3'b011;
      3'd5:    f_hall_code = 3'b001;
      3'd6:    f_hall_code = 3'b101;
      default: f_hall_code = 3'b100;
    endcase
  endfunction

  // Greater-or-equal compare lets a lowered period fire immediately instead of stalling.
  assign w_run  = enable && (period != '0);
  assign w_take = w_run && (r_cnt >= (period - c_period_one));

  always_comb begin
    w_sector_nxt = r_sector;
    if (r_sector == 3'd0 || r_sector == 3'd7) begin
      w_sector_nxt = 3'd1;
    end else if (w_take) begin
      if (dir) begin
        w_sector_nxt = (r_sector == 3'd6) ? 3'd1 : r_sector + 3'd1;
      end else begin
        w_sector_nxt = (r_sector == 3'd1) ? 3'd6 : r_sector - 3'd1;
      end
    end
  end

  always_comb begin
    w_hall_nxt = f_hall_code(w_sector_nxt);
    if (fault_mode == c_fault_lo) begin
      w_hall_nxt = 3'b000;
    end else if (fault_mode == c_fault_hi) begin
      w_hall_nxt = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sector   <= 3'd1;
      r_hall     <= 3'b100;
      r_position <= '0;
      r_step     <= 1'b0;
    end else begin
      r_sector <= w_sector_nxt;
      r_hall   <= w_hall_nxt;
      r_step   <= w_take;
      if (!w_run || w_take) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_period_one;
      end
      if (w_take) begin
        r_position <= dir ? (r_position + c_pos_one) : (r_position - c_pos_one);
      end
    end
  end

  assign hall_1   = r_hall[2];
  assign hall_2   = r_hall[1];
  assign hall_3   = r_hall[0];
  assign sector   = r_sector;
  assign position = r_position;
  assign step     = r_step;

endmodule
`default_nettype wire
